// File: rtl/filter_pkg.sv
// Shared types for the frame-synchronous filter mode scheduler.
package filter_pkg;
  localparam int FILTER_SEL_W = 3;

  typedef enum logic [FILTER_SEL_W-1:0] {
    PASS   = 3'd0,
    MOSAIC = 3'd1,
    RSV2   = 3'd2,
    RSV3   = 3'd3,
    RSV4   = 3'd4
  } filter_mode_e;

  typedef enum logic [1:0] {
    USER = 2'd0,
    PEND = 2'd1,
    OVR  = 2'd2
  } sched_state_e;
endpackage

// File: rtl/filter_sched_if.sv
// Game-FSM request channel into the filter scheduler.
// game_cancel exists only when FILTER_SCHED_CANCEL_EN is defined.
interface filter_sched_if;
  import filter_pkg::*;
  logic                    game_req_valid;
  logic [FILTER_SEL_W-1:0] game_req_mode;
  logic                    game_req_ready;
`ifdef FILTER_SCHED_CANCEL_EN
  logic                    game_cancel;
  modport master (output game_req_valid, game_req_mode, game_cancel, input game_req_ready);
  modport slave  (input game_req_valid, game_req_mode, game_cancel, output game_req_ready);
`else
  modport master (output game_req_valid, game_req_mode, input game_req_ready);
  modport slave  (input game_req_valid, game_req_mode, output game_req_ready);
`endif
endinterface

// File: rtl/frame_tick_gen.sv
// One-cycle pulse at the end of the last active display line.
module frame_tick_gen #(
  parameter int V_LAST = 479
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       DE,
  input  logic [9:0] y_pixel,
  output logic       frame_tick
);
  logic de_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) de_q <= 1'b0;
    else        de_q <= DE;
  end

  assign frame_tick = !DE && de_q && (y_pixel == 10'(V_LAST));
endmodule

// File: rtl/filter_sched.sv
// Arbitrates user button vs game-timed filter overrides; filter_sel changes only at frame ticks.
// Optional cancel path enabled by FILTER_SCHED_CANCEL_EN.
module filter_sched
  import filter_pkg::*;
#(
  parameter int NUM_MODES   = 5,
  parameter int HOLD_FRAMES = 120,
  parameter int V_LAST      = 479
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    DE,
  input  logic [9:0]              y_pixel,
  input  logic                    btn_next,
  filter_sched_if.slave           gif,
  output logic [FILTER_SEL_W-1:0] filter_sel,
  output logic                    override_active,
  output logic [9:0]              frames_left
);
  sched_state_e            state_q, state_d;
  logic [FILTER_SEL_W-1:0] user_q, user_d, sel_q, sel_d, pend_q, pend_d, in_mode;
  logic [9:0]              cnt_q, cnt_d;
  logic                    cflag_q, cflag_d;
  logic                    tick, cancel;

  frame_tick_gen #(.V_LAST(V_LAST)) u_tick (
    .clk(clk), .reset(reset), .DE(DE), .y_pixel(y_pixel), .frame_tick(tick)
  );

`ifdef FILTER_SCHED_CANCEL_EN
  assign cancel = gif.game_cancel;
`else
  assign cancel = 1'b0;
`endif

  assign in_mode = (int'(gif.game_req_mode) >= NUM_MODES) ? '0 : gif.game_req_mode;

  // Ticks read user_q, so a press in the tick cycle shows up one frame later.
  always_comb begin
    user_d = user_q;
    if (btn_next) user_d = (int'(user_q) >= NUM_MODES - 1) ? '0 : user_q + 1'b1;
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    pend_d  = pend_q;
    cnt_d   = cnt_q;
    cflag_d = cflag_q;
    unique case (state_q)
      USER: begin
        if (tick) sel_d = user_q;
        if (gif.game_req_valid) begin
          pend_d  = in_mode;
          state_d = PEND;
        end
      end
      PEND: begin
        if (cancel) begin
          state_d = USER;
          if (tick) sel_d = user_q;
        end else if (tick) begin
          sel_d   = pend_q;
          cnt_d   = 10'(HOLD_FRAMES);
          state_d = OVR;
        end
      end
      OVR: begin
        if (cancel) cflag_d = 1'b1;
        if (tick) begin
          if (cnt_q == 10'd1 || cflag_q) begin
            sel_d   = user_q;
            cnt_d   = '0;
            cflag_d = 1'b0;
            state_d = USER;
          end else begin
            cnt_d = cnt_q - 10'd1;
          end
        end
      end
      default: state_d = USER;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= USER;
      user_q  <= '0;
      sel_q   <= '0;
      pend_q  <= '0;
      cnt_q   <= '0;
      cflag_q <= 1'b0;
    end else begin
      state_q <= state_d;
      user_q  <= user_d;
      sel_q   <= sel_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      cflag_q <= cflag_d;
    end
  end

  assign gif.game_req_ready = (state_q == USER);
  assign filter_sel         = sel_q;
  assign override_active    = (state_q == OVR);
  assign frames_left        = cnt_q;
endmodule

// File: tb/tb_filter_sched.sv
// Randomized + directed bench for filter_sched against a frame-level behavioural model.
module tb_filter_sched;
  localparam int NUM_MODES = 5;
  localparam int HOLD      = 120;
  localparam int V_LAST    = 5;
  localparam int H_ACT     = 4;
  localparam int H_TOT     = 7;
  localparam int V_TOT     = 8;

  logic       clk = 0;
  logic       reset = 0;
  logic       DE = 0;
  logic [9:0] y_pixel = 0;
  logic       btn_next = 0;
  logic       cancel_b = 0;
  logic [2:0] filter_sel;
  logic       override_active;
  logic [9:0] frames_left;

  filter_sched_if gif();

  filter_sched #(.NUM_MODES(NUM_MODES), .HOLD_FRAMES(HOLD), .V_LAST(V_LAST)) dut (
    .clk(clk), .reset(reset), .DE(DE), .y_pixel(y_pixel), .btn_next(btn_next),
    .gif(gif), .filter_sel(filter_sel), .override_active(override_active),
    .frames_left(frames_left)
  );

  always #5 clk = ~clk;

  int h = 0, v = 0;
  int checks = 0, errors = 0, ticks = 0;

  // Model: which mode is shown, how many override frames remain, pending request.
  int m_user = 0, m_sel = 0, m_pmode = 0, m_left = 0;
  bit m_pend = 0, m_cflag = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit tick, ending;
    int u_old;
    if (!reset) begin
      m_user = 0; m_sel = 0; m_pmode = 0; m_left = 0; m_pend = 0; m_cflag = 0;
      return;
    end
    tick  = (h == H_ACT && v == V_LAST);
    u_old = m_user;
    if (btn_next) m_user = (m_user + 1) % NUM_MODES;
    if (tick) ticks++;
    if (m_left > 0) begin
      ending = tick && (m_left == 1 || m_cflag);
      if (ending) begin
        m_sel = u_old; m_left = 0; m_cflag = 0;
      end else begin
        if (tick) m_left--;
        if (cancel_b) m_cflag = 1;
      end
    end else if (m_pend) begin
      if (cancel_b) begin
        m_pend = 0;
        if (tick) m_sel = u_old;
      end else if (tick) begin
        m_pend = 0; m_sel = m_pmode; m_left = HOLD;
      end
    end else begin
      if (tick) m_sel = u_old;
      if (gif.game_req_valid) begin
        m_pend  = 1;
        m_pmode = (int'(gif.game_req_mode) < NUM_MODES) ? int'(gif.game_req_mode) : 0;
      end
    end
  endtask

  initial forever begin
    @(posedge clk or negedge reset);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    chk("sel", 32'(filter_sel), 32'(m_sel));
    chk("ovr", 32'(override_active), 32'(m_left > 0));
    chk("left", 32'(frames_left), 32'(m_left));
    chk("ready", 32'(gif.game_req_ready), 32'(!m_pend && m_left == 0));
  end

`ifdef FILTER_SCHED_CANCEL_EN
  always_comb gif.game_cancel = cancel_b;
`endif

  task automatic step();
    @(posedge clk);
    #1;
    h++;
    if (h == H_TOT) begin h = 0; v = (v + 1) % V_TOT; end
    DE      = (h < H_ACT) && (v <= V_LAST);
    y_pixel = 10'(v);
  endtask

  task automatic wait_ticks(int n);
    int t0 = ticks;
    int budget = n * H_TOT * V_TOT + 4 * H_TOT;
    while (ticks - t0 < n && budget > 0) begin step(); budget--; end
    if (ticks - t0 < n) chk("tick_timeout", 32'(ticks - t0), 32'(n));
  endtask

  task automatic wait_pos(int hh, int vv);
    int budget = 2 * H_TOT * V_TOT;
    while (!(h == hh && v == vv) && budget > 0) begin step(); budget--; end
    if (budget == 0) chk("pos_timeout", 32'(h), 32'(hh));
  endtask

  task automatic pulse_btn(int n);
    repeat (n) begin btn_next = 1; step(); btn_next = 0; step(); end
  endtask

  task automatic request(int mode);
    gif.game_req_valid = 1; gif.game_req_mode = 3'(mode);
    step();
    gif.game_req_valid = 0;
  endtask

  task automatic do_reset();
    reset = 0;
    repeat (3) step();
    @(negedge clk);
    chk("rst_sel", 32'(filter_sel), 0);
    chk("rst_ready", 32'(gif.game_req_ready), 1);
    chk("rst_left", 32'(frames_left), 0);
    chk("rst_ovr", 32'(override_active), 0);
    wait_pos(0, 0);
    reset = 1;
  endtask

  initial begin
    gif.game_req_valid = 0;
    gif.game_req_mode  = 0;
    do_reset();

    // user button path, including wrap 4 -> 0
    wait_pos(0, 2);
    pulse_btn(3);
    @(negedge clk); chk("btn_hold", 32'(filter_sel), 0);
    wait_ticks(1);
    @(negedge clk); chk("btn_tick", 32'(filter_sel), 3);
    pulse_btn(2);
    wait_ticks(1);
    @(negedge clk); chk("btn_wrap", 32'(filter_sel), 0);

    // basic override, button presses during it
    wait_pos(0, 2);
    request(1);
    @(negedge clk); chk("req_ready", 32'(gif.game_req_ready), 0);
    wait_ticks(1);
    @(negedge clk);
    chk("ovr_sel", 32'(filter_sel), 1);
    chk("ovr_left", 32'(frames_left), 120);
    chk("ovr_act", 32'(override_active), 1);
    pulse_btn(2);
    wait_ticks(119);
    @(negedge clk);
    chk("ovr_last_sel", 32'(filter_sel), 1);
    chk("ovr_last_left", 32'(frames_left), 1);
    wait_ticks(1);
    @(negedge clk);
    chk("ovr_end_sel", 32'(filter_sel), 2);
    chk("ovr_end_act", 32'(override_active), 0);

    // out-of-range game mode maps to pass
    wait_pos(0, 2);
    request(6);
    wait_ticks(1);
    @(negedge clk);
    chk("oor_sel", 32'(filter_sel), 0);
    chk("oor_act", 32'(override_active), 1);
`ifdef FILTER_SCHED_CANCEL_EN
    wait_ticks(70);
    @(negedge clk); chk("cxl_left50", 32'(frames_left), 50);
    cancel_b = 1; step(); cancel_b = 0;
    @(negedge clk); chk("cxl_still", 32'(override_active), 1);
    wait_ticks(1);
`else
    wait_ticks(120);
`endif
    @(negedge clk);
    chk("oor_end_sel", 32'(filter_sel), 2);
    chk("oor_end_left", 32'(frames_left), 0);

    // acceptance in the tick cycle
    wait_pos(0, 2);
    pulse_btn(1);
    wait_pos(H_ACT, V_LAST);
    request(1);
    @(negedge clk);
    chk("acc_tick_sel", 32'(filter_sel), 3);
    chk("acc_tick_ovr", 32'(override_active), 0);
    chk("acc_tick_rdy", 32'(gif.game_req_ready), 0);
    wait_ticks(1);
    @(negedge clk);
    chk("acc_next_sel", 32'(filter_sel), 1);
    chk("acc_next_left", 32'(frames_left), 120);
`ifdef FILTER_SCHED_CANCEL_EN
    cancel_b = 1; step(); cancel_b = 0;
    wait_ticks(1);
`else
    wait_ticks(120);
`endif
    @(negedge clk); chk("acc_end_sel", 32'(filter_sel), 3);

`ifdef FILTER_SCHED_CANCEL_EN
    wait_pos(0, 2);
    request(2);
    cancel_b = 1; step(); cancel_b = 0;
    @(negedge clk);
    chk("pend_cxl_rdy", 32'(gif.game_req_ready), 1);
    chk("pend_cxl_sel", 32'(filter_sel), 3);
`endif

    // reset mid-override
    wait_pos(0, 2);
    request(4);
    wait_ticks(3);
    do_reset();

    // random traffic
    for (int i = 0; i < 15000; i++) begin
      step();
      btn_next = ($urandom_range(39) == 0);
      gif.game_req_valid = ($urandom_range(7) == 0);
      gif.game_req_mode  = 3'($urandom_range(7));
`ifdef FILTER_SCHED_CANCEL_EN
      cancel_b = ($urandom_range(299) == 0);
`endif
    end
    btn_next = 0; gif.game_req_valid = 0; cancel_b = 0;
    step();
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
